instr_encoder: RTL

//  Inverse of the control decoder: packs decoded instruction fields
//  (cond/Op/Funct/Rn/Rd/Src2/Imm24) into 32-bit machine words. Streams them into

---
 rtl/instr_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields (cond/Op/Funct/Rn/Rd/
// Src2/Imm24) into 32-bit machine words and streams them into instruction
// memory at consecutive word addresses starting from BASE. Bundles the
// decoder cannot execute are consumed but dropped, and a sticky error is set.
//
// Optional feature: define INSTR_ENCODER_CHECKSUM_EN to add the o_csum
// port, a running XOR of every word written since the last start.

module instr_encoder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int BASE  = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_finish,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [3:0]      i_cond,
    input  logic [1:0]      i_op,
    input  logic [5:0]      i_funct,
    input  logic [3:0]      i_rn,
    input  logic [3:0]      i_rd,
    input  logic [11:0]     i_src2,
    input  logic [23:0]     i_imm24,
    output logic            o_imem_we,
    output logic [AW-1:0]   o_imem_addr,
    output logic [31:0]     o_imem_wdata,
    input  logic            i_imem_ready,
    output logic [AW:0]     o_count,
    output logic            o_full,
    output logic            o_err,
    output logic            o_done
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]     o_csum
`endif
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] BASE_C  = AW'(BASE);

    // S_DRAIN: finish seen while a word is still held; wait for its write.
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [AW:0]   r_count;
    logic          r_err;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0]   r_csum;
`endif

    logic          w_write_done;
    logic          w_full_next;
    logic          w_accept;
    logic          w_legal;
    logic [31:0]   w_word;
    logic          w_we_next;
    logic [AW:0]   w_count_inc;
    logic          w_full_after;

    // The held word counts toward capacity so the DEPTH-th word blocks intake.
    assign w_write_done = r_we & i_imem_ready;
    assign w_full_next  = (r_count + (AW+1)'(r_we)) >= DEPTH_C;
    assign o_in_ready   = (r_state == S_LOAD) & ~w_full_next & (~r_we | i_imem_ready);
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_we_next    = (w_accept & w_legal) | (r_we & ~i_imem_ready);
    assign w_count_inc  = r_count + (AW+1)'(1);
    assign w_full_after = w_write_done ? (w_count_inc == DEPTH_C) : (r_count == DEPTH_C);

    // Legality of the offered bundle: only opcodes/commands the decoder executes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_legal = 1'b1;
        case (i_op)
            2'b11: w_legal = 1'b0;
            2'b00: begin
                case (i_funct[4:1])
                    4'b0100, 4'b0010, 4'b0000, 4'b1100: w_legal = 1'b1;
                    // SDIV/UDIV exist only in register form.
                    4'b1011, 4'b1010:                   w_legal = ~i_funct[5];
                    default:                            w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b1;
        endcase
    end

    // Field packing: branches carry L in bit 24 and a 24-bit offset.
    always_comb begin
        w_word = {i_cond, i_op, i_funct, i_rn, i_rd, i_src2};
        if (i_op == 2'b10) begin
            w_word = {i_cond, 3'b101, i_funct[4], i_imm24};
        end
    end

    // Control FSM, output register, address/count tracking and sticky error.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= BASE_C;
            r_wdata <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else if (i_start) begin
            // start overrides finish and any handshake this cycle.
            r_state <= S_LOAD;
            r_we    <= 1'b0;
            r_addr  <= BASE_C;
            r_count <= '0;
            r_err   <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            if (w_write_done) begin
                r_we    <= 1'b0;
                r_count <= w_count_inc;
                // Address parks on the last slot once the region is full.
                if (w_count_inc != DEPTH_C) begin
                    r_addr <= r_addr + AW'(1);
                end
`ifdef INSTR_ENCODER_CHECKSUM_EN
                r_csum  <= r_csum ^ r_wdata;
`endif
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                end else begin
                    r_err   <= 1'b1;
                end
            end
            case (r_state)
                S_LOAD: begin
                    if (i_finish | w_full_after) begin
                        r_state <= w_we_next ? S_DRAIN : S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (!w_we_next) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_count      = r_count;
    assign o_full       = (r_count == DEPTH_C);
    assign o_err        = r_err;
    assign o_done       = (r_state == S_DONE);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    assign o_csum       = r_csum;
`endif

endmodule
